cmp_sched: RTL and testbench
============================

Name: cmp_sched

Overview:
Scheduler that shares one external branch comparator (operands in; less/equal flags out) between two requesters.
- Requester 0: branch unit. Resolves B-type conditions and computes the branch target.
- Requester 1: SLT/SLTU execution path. Produces a zero-extended set-less-than result.
- Arbitration is round-robin, with a 3-state sequencer and valid/ready handshakes on both request and response sides.

Parameters:
XLEN, 32, operand/PC/immediate width in bits
STAT_W, 16, width of the statistics counters (Optional Feature only)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  abort in-flight operation (pipeline redirect)
req0_valid  input  1  branch request valid
req0_ready  output  1  branch request accepted this cycle
req0_funct3  input  3  B-type funct3
req0_a  input  XLEN  rs1 value
req0_b  input  XLEN  rs2 value
req0_pc  input  XLEN  branch PC
req0_imm  input  XLEN  sign-extended B-immediate
rsp0_valid  output  1  branch response valid
rsp0_ready  input  1  branch response consumed
rsp0_taken  output  1  branch taken
rsp0_target  output  XLEN  pc+imm
rsp0_illegal  output  1  funct3 is 010 or 011
req1_valid  input  1  SLT request valid
req1_ready  output  1  SLT request accepted
req1_unsigned  input  1  1 = SLTU
req1_a  input  XLEN  operand A
req1_b  input  XLEN  operand B
rsp1_valid  output  1  SLT response valid
rsp1_ready  input  1  SLT response consumed
rsp1_result  output  XLEN  zero-extended less flag
cmp_a  output  XLEN  comparator operand A
cmp_b  output  XLEN  comparator operand B
cmp_unsigned  output  1  comparator unsigned select
cmp_less  input  1  comparator A<B (combinational from cmp_*)
cmp_equal  input  1  comparator A==B
stat_grant0  output  STAT_W  branch grants (Optional Feature)
stat_grant1  output  STAT_W  SLT grants (Optional Feature)
stat_taken  output  STAT_W  taken branches (Optional Feature)

Behaviour:
- Reset (async, rst=1):
  - State is IDLE; last_grant=1, so requester 0 wins first.
  - All rsp outputs, readies, cmp_* and stat_* are 0.
  - The operand latch is cleared.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - req0_ready/req1_ready are combinational. Exactly one may be high, and only in IDLE with flush=0.
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester that is not last_grant.
  - On grant: latch operands, owner id, funct3/unsigned, pc and imm; update last_grant; go to ISSUE.
- ISSUE (1 cycle):
  - cmp_a/cmp_b/cmp_unsigned are driven from the latch. They hold 0 in other states.
  - Unsigned select: owner 0 uses funct3[1]; owner 1 uses req1_unsigned.
  - Sample cmp_less/cmp_equal into result registers; go to RESP.
- Taken rule, by funct3:
  - 000: equal
  - 001: !equal
  - 100: less
  - 101: !less
  - 110: less
  - 111: !less
  - 010/011: taken=0, illegal=1
- Target: pc+imm, truncated to XLEN (wraps modulo 2^XLEN). Computed for illegal funct3 too.
- rsp1_result: {XLEN-1 zeros, less}.
- RESP:
  - The owner's rsp_valid=1 and its payload is held stable.
  - The other requester's rsp_valid stays 0.
  - On owner rsp_ready=1: go to IDLE.
- Latency: accept at cycle N → rsp_valid at N+2. Minimum back-to-back issue interval is 3 cycles.
- flush=1:
  - Forces IDLE next cycle from any state, with no response emitted; a flushed RESP is dropped.
  - No grant occurs in a flush cycle. last_grant keeps its value.
- rsp_ready while rsp_valid=0: ignored.
- Reset asserted mid-operation: the transaction is lost and outputs return to reset values immediately.

Optional Feature:
- Macro: CMP_SCHED_STATS_EN.
- Defined:
  - stat_grant0/stat_grant1 increment on each grant to that requester.
  - stat_taken increments when rsp0 completes a handshake with taken=1.
  - All counters saturate at 2^STAT_W-1, are cleared by rst, and are unaffected by flush. A flushed grant still counts.
- Undefined: the stat ports are present but tied to 0, and no counter registers exist.

Test Plan:
- Reset, then req0 BEQ a=5 b=5 pc=0x100 imm=0x20 → cmp_a=5 in ISSUE; rsp0_valid 2 cycles after accept, taken=1, target=0x120, illegal=0.
- req0 BLT a=0xFFFFFFFF b=1 with ext comparator model → taken=1. BLTU same operands → taken=0, cmp_unsigned=1.
- req0 and req1 both valid continuously → grants alternate 0,1,0,1. With req1 SLTU a=1 b=2, rsp1_result=0x00000001.
- rsp0_ready held 0 for 5 cycles → rsp0_valid and payload stable, req*_ready=0 throughout; release → IDLE next cycle.
- flush asserted during ISSUE and separately during RESP → no rsp_valid pulse, IDLE next cycle, next request served normally. Funct3=010 → illegal=1, taken=0. pc=0xFFFFFFF0 imm=0x20 → target=0x10.
- With CMP_SCHED_STATS_EN, STAT_W=2: 5 taken branches → stat_taken=3 (saturated), stat_grant0=3. Without the macro, all stat ports read 0.

Source files
------------

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one external comparator between a branch unit and an SLT path.
// Optional grant/taken statistics counters are enabled with CMP_SCHED_STATS_EN.
module cmp_sched #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [2:0]        req0_funct3,
    input  logic [XLEN-1:0]   req0_a,
    input  logic [XLEN-1:0]   req0_b,
    input  logic [XLEN-1:0]   req0_pc,
    input  logic [XLEN-1:0]   req0_imm,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp0_taken,
    output logic [XLEN-1:0]   rsp0_target,
    output logic              rsp0_illegal,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_unsigned,
    input  logic [XLEN-1:0]   req1_a,
    input  logic [XLEN-1:0]   req1_b,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [XLEN-1:0]   rsp1_result,
    output logic [XLEN-1:0]   cmp_a,
    output logic [XLEN-1:0]   cmp_b,
    output logic              cmp_unsigned,
    input  logic              cmp_less,
    input  logic              cmp_equal,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1,
    output logic [STAT_W-1:0] stat_taken
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    state_e            state_q;
    logic              last_grant_q;
    logic              owner_q;
    logic [2:0]        funct3_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   imm_q;
    logic [XLEN-1:0]   cmp_a_q;
    logic [XLEN-1:0]   cmp_b_q;
    logic              cmp_unsigned_q;
    logic              rsp0_valid_q;
    logic              rsp0_taken_q;
    logic              rsp0_illegal_q;
    logic [XLEN-1:0]   rsp0_target_q;
    logic              rsp1_valid_q;
    logic              rsp1_less_q;

    logic idle_ok;
    logic grant0;
    logic grant1;
    logic taken_now;
    logic illegal_now;
    logic rsp_done;

    // Ties go to whichever requester did not win last time.
    always_comb begin
        idle_ok = (state_q == StIdle) && !flush;
        grant0  = idle_ok && req0_valid && (!req1_valid || last_grant_q);
        grant1  = idle_ok && req1_valid && (!req0_valid || !last_grant_q);
    end

    always_comb begin
        taken_now = 1'b0;
        unique case (funct3_q)
            3'b000:         taken_now = cmp_equal;
            3'b001:         taken_now = !cmp_equal;
            3'b100, 3'b110: taken_now = cmp_less;
            3'b101, 3'b111: taken_now = !cmp_less;
            default:        taken_now = 1'b0;
        endcase
        illegal_now = (funct3_q[2:1] == 2'b01);
        rsp_done    = owner_q ? rsp1_ready : rsp0_ready;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            last_grant_q   <= 1'b1;
            owner_q        <= 1'b0;
            funct3_q       <= '0;
            pc_q           <= '0;
            imm_q          <= '0;
            cmp_a_q        <= '0;
            cmp_b_q        <= '0;
            cmp_unsigned_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp0_taken_q   <= 1'b0;
            rsp0_illegal_q <= 1'b0;
            rsp0_target_q  <= '0;
            rsp1_valid_q   <= 1'b0;
            rsp1_less_q    <= 1'b0;
        end else if (flush) begin
            state_q        <= StIdle;
            cmp_a_q        <= '0;
            cmp_b_q        <= '0;
            cmp_unsigned_q <= 1'b0;
            rsp0_valid_q   <= 1'b0;
            rsp1_valid_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        owner_q        <= grant1;
                        last_grant_q   <= grant1;
                        funct3_q       <= req0_funct3;
                        pc_q           <= req0_pc;
                        imm_q          <= req0_imm;
                        cmp_a_q        <= grant1 ? req1_a : req0_a;
                        cmp_b_q        <= grant1 ? req1_b : req0_b;
                        cmp_unsigned_q <= grant1 ? req1_unsigned : req0_funct3[1];
                        state_q        <= StIssue;
                    end
                end
                StIssue: begin
                    // Comparator result is valid only while the latched operands are driven.
                    if (!owner_q) begin
                        rsp0_taken_q   <= taken_now;
                        rsp0_illegal_q <= illegal_now;
                        rsp0_target_q  <= pc_q + imm_q;
                        rsp0_valid_q   <= 1'b1;
                    end else begin
                        rsp1_less_q    <= cmp_less;
                        rsp1_valid_q   <= 1'b1;
                    end
                    cmp_a_q        <= '0;
                    cmp_b_q        <= '0;
                    cmp_unsigned_q <= 1'b0;
                    state_q        <= StResp;
                end
                StResp: begin
                    if (rsp_done) begin
                        rsp0_valid_q <= 1'b0;
                        rsp1_valid_q <= 1'b0;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req0_ready   = grant0;
    assign req1_ready   = grant1;
    assign cmp_a        = cmp_a_q;
    assign cmp_b        = cmp_b_q;
    assign cmp_unsigned = cmp_unsigned_q;
    assign rsp0_valid   = rsp0_valid_q;
    assign rsp0_taken   = rsp0_taken_q;
    assign rsp0_illegal = rsp0_illegal_q;
    assign rsp0_target  = rsp0_target_q;
    assign rsp1_valid   = rsp1_valid_q;
    assign rsp1_result  = {{(XLEN-1){1'b0}}, rsp1_less_q};

`ifdef CMP_SCHED_STATS_EN
    logic [STAT_W-1:0] stat_grant0_q;
    logic [STAT_W-1:0] stat_grant1_q;
    logic [STAT_W-1:0] stat_taken_q;
    logic              taken_hs;

    // A flushed response is dropped, so it never counts as a taken handshake.
    assign taken_hs = rsp0_valid_q && rsp0_ready && rsp0_taken_q && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant0_q <= '0;
            stat_grant1_q <= '0;
            stat_taken_q  <= '0;
        end else begin
            if (grant0 && (stat_grant0_q != '1)) stat_grant0_q <= stat_grant0_q + 1'b1;
            if (grant1 && (stat_grant1_q != '1)) stat_grant1_q <= stat_grant1_q + 1'b1;
            if (taken_hs && (stat_taken_q != '1)) stat_taken_q <= stat_taken_q + 1'b1;
        end
    end

    assign stat_grant0 = stat_grant0_q;
    assign stat_grant1 = stat_grant1_q;
    assign stat_taken  = stat_taken_q;
`else
    assign stat_grant0 = '0;
    assign stat_grant1 = '0;
    assign stat_taken  = '0;
`endif

endmodule

// File: tb/tb_cmp_sched.sv
// Directed, table-driven bench for cmp_sched with a behavioural external comparator.
module tb_cmp_sched;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned STAT_W = 2;

    logic clk, rst, flush;
    logic req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_taken, rsp0_illegal;
    logic [2:0] req0_funct3;
    logic [XLEN-1:0] req0_a, req0_b, req0_pc, req0_imm, rsp0_target;
    logic req1_valid, req1_ready, req1_unsigned, rsp1_valid, rsp1_ready;
    logic [XLEN-1:0] req1_a, req1_b, rsp1_result;
    logic [XLEN-1:0] cmp_a, cmp_b;
    logic cmp_unsigned, cmp_less, cmp_equal;
    logic [STAT_W-1:0] stat_grant0, stat_grant1, stat_taken;

    cmp_sched #(.XLEN(XLEN), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_funct3(req0_funct3),
        .req0_a(req0_a), .req0_b(req0_b), .req0_pc(req0_pc), .req0_imm(req0_imm),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_taken(rsp0_taken),
        .rsp0_target(rsp0_target), .rsp0_illegal(rsp0_illegal),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_unsigned(req1_unsigned),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_unsigned(cmp_unsigned),
        .cmp_less(cmp_less), .cmp_equal(cmp_equal),
        .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_taken(stat_taken)
    );

    // External comparator
    always_comb begin
        cmp_less  = cmp_unsigned ? (cmp_a < cmp_b) : ($signed(cmp_a) < $signed(cmp_b));
        cmp_equal = (cmp_a == cmp_b);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        req;
        logic [2:0]  f3;
        logic        uns;
        logic [31:0] a, b, pc, imm;
        logic        taken, illegal;
        logic [31:0] target, result;
        logic        cmp_uns;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int g0 = 0, g1 = 0, tk = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic req, input logic [2:0] f3, input logic uns,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic taken, input logic illegal,
                                input logic [31:0] target, input logic [31:0] result,
                                input logic cmp_uns);
        vec_t v;
        v.req = req; v.f3 = f3; v.uns = uns; v.a = a; v.b = b; v.pc = pc; v.imm = imm;
        v.taken = taken; v.illegal = illegal; v.target = target; v.result = result;
        v.cmp_uns = cmp_uns;
        return v;
    endfunction

    function automatic int sat(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic drive_req(input vec_t v);
        if (!v.req) begin
            req0_valid = 1'b1; req0_funct3 = v.f3; req0_a = v.a; req0_b = v.b;
            req0_pc = v.pc; req0_imm = v.imm;
        end else begin
            req1_valid = 1'b1; req1_unsigned = v.uns; req1_a = v.a; req1_b = v.b;
        end
    endtask

    // Returns at the negedge of the ISSUE cycle with request valids dropped.
    task automatic accept(input vec_t v, input string tag);
        int   n;
        logic rdy;
        @(negedge clk);
        drive_req(v);
        #1;
        n = 0;
        rdy = v.req ? req1_ready : req0_ready;
        while (!rdy && n < 10) begin
            @(negedge clk);
            #1;
            rdy = v.req ? req1_ready : req0_ready;
            n++;
        end
        check({tag, "_accept_ready"}, {63'd0, rdy}, 64'd1);
        if (rdy) begin
            @(posedge clk);
            if (v.req) g1++; else g0++;
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        accept(v, tag);
        check({tag, "_issue_cmp_a"}, {32'd0, cmp_a}, {32'd0, v.a});
        check({tag, "_issue_cmp_b"}, {32'd0, cmp_b}, {32'd0, v.b});
        check({tag, "_issue_cmp_uns"}, {63'd0, cmp_unsigned}, {63'd0, v.cmp_uns});
        check({tag, "_issue_no_rsp"}, {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        @(negedge clk);
        if (!v.req) begin
            check({tag, "_rsp_valid"}, {62'd0, rsp0_valid, rsp1_valid}, 64'd2);
            check({tag, "_taken"}, {63'd0, rsp0_taken}, {63'd0, v.taken});
            check({tag, "_illegal"}, {63'd0, rsp0_illegal}, {63'd0, v.illegal});
            check({tag, "_target"}, {32'd0, rsp0_target}, {32'd0, v.target});
            rsp0_ready = 1'b1;
            if (v.taken) tk++;
        end else begin
            check({tag, "_rsp_valid"}, {62'd0, rsp0_valid, rsp1_valid}, 64'd1);
            check({tag, "_result"}, {32'd0, rsp1_result}, {32'd0, v.result});
            rsp1_ready = 1'b1;
        end
        @(negedge clk);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        check({tag, "_rsp_done"}, {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
    endtask

    vec_t vecs[12];
    vec_t beq;

    initial begin
        int   ng, r0, r1;
        logic gseq[4];
        int   gcyc[4];

        rst = 1'b1; flush = 1'b0;
        req0_valid = 0; req0_funct3 = 0; req0_a = 0; req0_b = 0; req0_pc = 0; req0_imm = 0;
        req1_valid = 0; req1_unsigned = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;

        //           req f3      uns a             b             pc            imm           tk il target        result cu
        vecs[0]  = mk(0, 3'b000, 0, 32'd5,        32'd5,        32'h100,      32'h20,       1, 0, 32'h120,      0, 0);
        vecs[1]  = mk(0, 3'b100, 0, 32'hFFFFFFFF, 32'd1,        32'h200,      32'hFFFFFFF0, 1, 0, 32'h1F0,      0, 0);
        vecs[2]  = mk(0, 3'b110, 0, 32'hFFFFFFFF, 32'd1,        32'h0,        32'h4,        0, 0, 32'h4,        0, 1);
        vecs[3]  = mk(0, 3'b001, 0, 32'd5,        32'd5,        32'h1000,     32'h8,        0, 0, 32'h1008,     0, 0);
        vecs[4]  = mk(0, 3'b101, 0, 32'd3,        32'd7,        32'h10,       32'h10,       0, 0, 32'h20,       0, 0);
        vecs[5]  = mk(0, 3'b111, 0, 32'h80000000, 32'd1,        32'h40,       32'h0,        1, 0, 32'h40,       0, 1);
        vecs[6]  = mk(0, 3'b010, 0, 32'd1,        32'd2,        32'hFFFFFFF0, 32'h20,       0, 1, 32'h10,       0, 1);
        vecs[7]  = mk(0, 3'b011, 0, 32'd9,        32'd9,        32'h0,        32'h0,        0, 1, 32'h0,        0, 1);
        vecs[8]  = mk(1, 3'b000, 0, 32'hFFFFFFFF, 32'd0,        0,            0,            0, 0, 0,            1, 0);
        vecs[9]  = mk(1, 3'b000, 1, 32'hFFFFFFFF, 32'd0,        0,            0,            0, 0, 0,            0, 1);
        vecs[10] = mk(1, 3'b000, 1, 32'd1,        32'd2,        0,            0,            0, 0, 0,            1, 1);
        vecs[11] = mk(1, 3'b000, 0, 32'd7,        32'd7,        0,            0,            0, 0, 0,            0, 0);
        beq = vecs[0];

        repeat (2) @(negedge clk);
        check("reset_rsp_valid", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        check("reset_cmp", {31'd0, cmp_unsigned, cmp_a}, 64'd0);
        check("reset_rsp1_result", {32'd0, rsp1_result}, 64'd0);
        check("reset_stats", {58'd0, stat_grant0, stat_grant1, stat_taken}, 64'd0);
        rst = 1'b0;

        // No grant during a flush cycle
        @(negedge clk);
        req0_valid = 1'b1; flush = 1'b1;
        #1;
        check("flush_blocks_grant", {63'd0, req0_ready}, 64'd0);
        @(negedge clk);
        flush = 1'b0; req0_valid = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("v%0d", i));

        // Response back-pressure: payload holds, no new grant
        accept(beq, "bp");
        @(negedge clk);
        req1_valid = 1'b1; req1_unsigned = 1'b1; req1_a = 32'd1; req1_b = 32'd2;
        req0_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("bp%0d_rsp0_valid", i), {63'd0, rsp0_valid}, 64'd1);
            check($sformatf("bp%0d_target", i), {32'd0, rsp0_target}, 64'h120);
            check($sformatf("bp%0d_readies", i), {62'd0, req0_ready, req1_ready}, 64'd0);
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        tk++;
        @(negedge clk);
        rsp0_ready = 1'b0;
        #1;
        check("bp_release_valid", {63'd0, rsp0_valid}, 64'd0);
        check("bp_release_rr", {62'd0, req0_ready, req1_ready}, 64'd1);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Flush during ISSUE
        accept(beq, "fi");
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fi_no_rsp", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        req0_valid = 1'b1;
        #1;
        check("fi_idle", {63'd0, req0_ready}, 64'd1);
        req0_valid = 1'b0;
        @(negedge clk);
        check("fi_no_rsp_late", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);

        // Flush during RESP
        accept(beq, "fr");
        @(negedge clk);
        check("fr_rsp_before", {63'd0, rsp0_valid}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fr_dropped", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        run_vec(vecs[6], "after_flush");

        // Reset mid-RESP takes effect immediately
        accept(beq, "rs");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rs_rsp_cleared", {62'd0, rsp0_valid, rsp1_valid}, 64'd0);
        check("rs_target_cleared", {32'd0, rsp0_target}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        g0 = 0; g1 = 0; tk = 0;

        // Both requesters continuously valid
        ng = 0; r0 = 0; r1 = 0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_funct3 = 3'b000; req0_a = 5; req0_b = 5; req0_pc = 0; req0_imm = 0;
        req1_unsigned = 1'b1; req1_a = 1; req1_b = 2;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) begin req0_valid = 1'b1; req1_valid = 1'b1; end
            if (ng >= 4) begin req0_valid = 1'b0; req1_valid = 1'b0; end
            #1;
            if (rsp0_valid) begin
                r0++; tk++;
                check($sformatf("alt_taken_%0d", i), {63'd0, rsp0_taken}, 64'd1);
            end
            if (rsp1_valid) begin
                r1++;
                check($sformatf("alt_result_%0d", i), {32'd0, rsp1_result}, 64'd1);
            end
            if ((req0_ready || req1_ready) && ng < 4) begin
                gseq[ng] = req1_ready; gcyc[ng] = i; ng++;
                if (req1_ready) g1++; else g0++;
            end
        end
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        check("alt_grants", ng, 64'd4);
        if (ng == 4) begin
            check("alt_order", {60'd0, gseq[0], gseq[1], gseq[2], gseq[3]}, 64'b0101);
            check("alt_gap1", gcyc[1] - gcyc[0], 64'd3);
            check("alt_gap3", gcyc[3] - gcyc[2], 64'd3);
        end
        check("alt_rsp_counts", {r0[31:0], r1[31:0]}, {32'd2, 32'd2});

        for (int i = 0; i < 3; i++) run_vec(beq, $sformatf("st%0d", i));

`ifdef CMP_SCHED_STATS_EN
        check("stat_grant0", {62'd0, stat_grant0}, sat(g0));
        check("stat_grant1", {62'd0, stat_grant1}, sat(g1));
        check("stat_taken", {62'd0, stat_taken}, sat(tk));
`else
        check("stat_grant0_tied", {62'd0, stat_grant0}, 64'd0);
        check("stat_grant1_tied", {62'd0, stat_grant1}, 64'd0);
        check("stat_taken_tied", {62'd0, stat_taken}, 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
